// File: rtl/mcpu_dram_copier.sv
// mcpu_dram_copier: second bus master on the MCPU DRAM bus that copies a block
// (src -> dst) or fills a block with a constant, one word at a time in
// ascending address order. All outputs are registered and follow the FSM
// state by one cycle, so the bus activity of a state appears in the next cycle.
module mcpu_dram_copier #(
  parameter int DRAM_DATA_BITS = 16,
  parameter int DRAM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [DRAM_ADDR_BITS-1:0] src_addr,
  input  logic [DRAM_ADDR_BITS-1:0] dst_addr,
  input  logic [DRAM_ADDR_BITS-1:0] length,
  input  logic [DRAM_DATA_BITS-1:0] fill_value,
  output logic                      busy,
  output logic                      done,
  output logic [DRAM_ADDR_BITS-1:0] words_done,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  inout  wire  [DRAM_DATA_BITS-1:0] data_bus,
  output logic                      dram_we,
  output logic                      dram_re
);

  typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, DONE} state_t;

  state_t state, state_next;

  // Operation context latched at acceptance; inputs are don't-care afterwards.
  logic                      mode_r;
  logic [DRAM_DATA_BITS-1:0] fill_r;
  logic [DRAM_ADDR_BITS-1:0] src_ptr;
  logic [DRAM_ADDR_BITS-1:0] dst_ptr;
  logic [DRAM_ADDR_BITS-1:0] remaining;
  logic [DRAM_DATA_BITS-1:0] data_reg;
  logic [DRAM_DATA_BITS-1:0] wdata;

  // Next-cycle values of the registered bus outputs.
  logic                      re_d;
  logic                      we_d;
  logic                      done_d;
  logic [DRAM_ADDR_BITS-1:0] addr_d;
  logic [DRAM_DATA_BITS-1:0] wdata_d;

  logic accept;
  assign accept = (state == IDLE) && start;

  // The write data register is only put on the bus while dram_we is high;
  // the drive enable is dram_we itself, so read and drive can never overlap.
  assign data_bus = dram_we ? wdata : 'z;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default at the top of each combinational block guarantees every
    // path assigns the variable, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_next = DONE;
          else if (mode)    state_next = WRITE;
          else              state_next = READ;
        end
      end
      READ:  state_next = TURN;
      TURN:  state_next = WRITE;
      WRITE: begin
        if (remaining == DRAM_ADDR_BITS'(1)) state_next = DONE;
        else if (mode_r)                      state_next = WRITE;
        else                                  state_next = READ;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: bus values to be registered for the following cycle.
  always_comb begin
    re_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = dram_addr;
    wdata_d = mode_r ? fill_r : data_reg;
    unique case (state)
      READ: begin
        re_d   = 1'b1;
        addr_d = src_ptr;
      end
      WRITE: begin
        we_d   = 1'b1;
        addr_d = dst_ptr;
      end
      DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers, pointers, counters and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only control and visible outputs are reset; the pointers and data
      // registers are always loaded before use, so they carry no reset.
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      dram_addr  <= '0;
      dram_we    <= 1'b0;
      dram_re    <= 1'b0;
    end else begin
      dram_re   <= re_d;
      dram_we   <= we_d;
      done      <= done_d;
      dram_addr <= addr_d;
      wdata     <= wdata_d;

      // The RAM drives the bus combinationally during our read cycle.
      if (dram_re) data_reg <= data_bus;

      // Count words as the bus write actually happens.
      if (dram_we) words_done <= words_done + DRAM_ADDR_BITS'(1);

      if (state == WRITE) begin
        src_ptr   <= src_ptr + DRAM_ADDR_BITS'(1);
        dst_ptr   <= dst_ptr + DRAM_ADDR_BITS'(1);
        remaining <= remaining - DRAM_ADDR_BITS'(1);
      end

      if (accept) begin
        src_ptr    <= src_addr;
        dst_ptr    <= dst_addr;
        remaining  <= length;
        mode_r     <= mode;
        fill_r     <= fill_value;
        words_done <= '0;
        busy       <= (length != '0);
      end else if (state == DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_dram_copier.sv
// Testbench for mcpu_dram_copier: behavioural DRAM on the shared bus, a shadow
// memory model updated per operation, a per-cycle bus discipline monitor, a
// table of directed operations and hand-written ignored-start / reset cases.
module tb_mcpu_dram_copier;

  localparam int DW    = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] length;
  logic [DW-1:0] fill_value;
  logic          busy;
  logic          done;
  logic [AW-1:0] words_done;
  logic [AW-1:0] dram_addr;
  wire  [DW-1:0] data_bus;
  logic          dram_we;
  logic          dram_re;

  logic [DW-1:0] mem    [0:DEPTH-1];
  logic [DW-1:0] shadow [0:DEPTH-1];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic mon_en = 1'b0;

  mcpu_dram_copier #(.DRAM_DATA_BITS(DW), .DRAM_ADDR_BITS(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .dram_addr  (dram_addr),
    .data_bus   (data_bus),
    .dram_we    (dram_we),
    .dram_re    (dram_re)
  );

  always #5 clk = ~clk;

  // Behavioural DRAM: combinational read drive, write captured on posedge.
  assign data_bus = (dram_re === 1'b1) ? mem[dram_addr] : 'z;
  always @(posedge clk) if (dram_we === 1'b1) mem[dram_addr] <= data_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus discipline monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("re_we_exclusive", 32'(dram_re & dram_we), 32'd0);
      if (dram_we === 1'b1)
        check("bus_no_x_on_write", 32'($isunknown(data_bus)), 32'd0);
      else if (dram_re !== 1'b1)
        check("bus_z_when_idle", 32'(data_bus === 'z), 32'd1);
      if (dram_we === 1'b1) we_cnt++;
      if (dram_re === 1'b1) re_cnt++;
    end
  end

  typedef struct {
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill;
    int            lat;
    logic [AW-1:0] exp_words;
    logic [AW-1:0] spot_addr;
    logic [DW-1:0] spot_val;
    bit            poke;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  task automatic model_op(input vec_t v);
    logic [AW-1:0] s, d;
    s = v.src;
    d = v.dst;
    for (int i = 0; i < int'(v.len); i++) begin
      shadow[d] = v.mode ? v.fill : shadow[s];
      s = s + AW'(1);
      d = d + AW'(1);
    end
  endtask

  task automatic compare_image(input string tag);
    int bad;
    bad = -1;
    for (int a = 0; a < DEPTH; a++)
      if (bad < 0 && mem[a] !== shadow[a]) bad = a;
    check({tag, "_image_first_bad_addr"}, bad, 32'hFFFF_FFFF);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int  n;
    int  we0, re0, extra;
    bit  got, busy_ok;
    we0 = we_cnt;
    re0 = re_cnt;
    @(posedge clk); #1;
    mode = v.mode; src_addr = v.src; dst_addr = v.dst;
    length = v.len; fill_value = v.fill; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the other inputs: they must have been latched at acceptance.
    mode = ~v.mode; src_addr = ~v.src; dst_addr = ~v.dst;
    length = ~v.len; fill_value = ~v.fill;
    n = 1; got = 1'b0; busy_ok = 1'b1;
    while (n <= 200 && !got) begin
      if (v.poke && n == 2) start = 1'b1;
      if (v.poke && n == 3) start = 1'b0;
      @(negedge clk);
      if (n == 1) check({tag, "_busy_cycle1"}, 32'(busy), 32'(v.len != '0));
      if (done) got = 1'b1;
      else begin
        if (v.len != '0 && !busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_done_latency"}, got ? n : 0, v.lat);
    check({tag, "_busy_until_done"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_words_done"}, 32'(words_done), 32'(v.exp_words));
    model_op(v);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_no_extra_done"}, extra, 0);
    check({tag, "_words_done_held"}, 32'(words_done), 32'(v.exp_words));
    check({tag, "_write_count"}, we_cnt - we0, int'(v.len));
    check({tag, "_read_count"}, re_cnt - re0, v.mode ? 0 : int'(v.len));
    check({tag, "_spot_word"}, 32'(mem[v.spot_addr]), 32'(v.spot_val));
    compare_image(tag);
  endtask

  initial begin
    int   wcount, n, junk;
    vec_t v;

    //              mode  src       dst       len     fill       lat words  spot_addr spot_val  poke
    vecs[0] = '{1'b0, 14'h0100, 14'h0200, 14'd4, 16'h0000, 14, 14'd4, 14'h0203, 16'hA003, 1'b0};
    vecs[1] = '{1'b1, 14'h0000, 14'h0010, 14'd3, 16'hBEEF,  5, 14'd3, 14'h0012, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 14'h3FFF, 14'h0300, 14'd2, 16'h0000,  8, 14'd2, 14'h0300, 16'h65A5, 1'b0};
    vecs[3] = '{1'b1, 14'h0000, 14'h3FFE, 14'd4, 16'h1234,  6, 14'd4, 14'h0001, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 14'h0400, 14'h0401, 14'd3, 16'h0000, 11, 14'd3, 14'h0403, 16'h5E5A, 1'b0};
    vecs[5] = '{1'b0, 14'h0000, 14'h0000, 14'd0, 16'h0000,  2, 14'd0, 14'h0000, 16'h1234, 1'b0};
    vecs[6] = '{1'b0, 14'h0500, 14'h0600, 14'd1, 16'h0000,  5, 14'd1, 14'h0600, 16'h5F5A, 1'b0};
    vecs[7] = '{1'b1, 14'h0000, 14'h0700, 14'd5, 16'h5555,  7, 14'd5, 14'h0704, 16'h5555, 1'b1};

    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) mem[14'h0100 + i] = 16'hA000 + DW'(i);
    for (int a = 0; a < DEPTH; a++) shadow[a] = mem[a];

    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_words_done", 32'(words_done), 32'd0);
    check("reset_dram_addr", 32'(dram_addr), 32'd0);
    check("reset_dram_we", 32'(dram_we), 32'd0);
    check("reset_dram_re", 32'(dram_re), 32'd0);
    check("reset_bus_z", 32'(data_bus === 'z), 32'd1);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a copy, right after the second write cycle.
    @(posedge clk); #1;
    mode = 1'b0; src_addr = 14'h0100; dst_addr = 14'h0900; length = 14'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wcount = 0; n = 0;
    while (wcount < 2 && n < 100) begin
      @(negedge clk);
      if (dram_we) wcount++;
      n++;
    end
    check("midrst_two_writes_seen", wcount, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dram_we", 32'(dram_we), 32'd0);
    check("midrst_dram_re", 32'(dram_re), 32'd0);
    check("midrst_bus_z", 32'(data_bus === 'z), 32'd1);
    junk = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || dram_we || dram_re) junk++;
    end
    check("midrst_bus_quiet", junk, 0);
    shadow[14'h0900] = shadow[14'h0100];
    shadow[14'h0901] = shadow[14'h0101];
    compare_image("midrst");

    v = '{1'b0, 14'h0101, 14'h0A00, 14'd1, 16'h0000, 5, 14'd1, 14'h0A00, 16'hA001, 1'b0};
    run_op(v, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
